serial_adder_ctrl: RTL and testbench

//  Bit-serial WIDTH-bit adder wrapped around one fulladder_structural instance.

---
 rtl/serial_adder_ctrl.sv | 145 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell processes one bit pair per clock, LSB first.
// Sum and carry-out are registered and announced with a single-cycle done pulse.

module fulladder_structural (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic f_s,
    output logic f_c
);
    logic xy_s;
    logic g_s;
    logic p_s;

    xor u_x0 (xy_s, x, y);
    xor u_x1 (f_s, xy_s, z);
    and u_a0 (g_s, x, y);
    and u_a1 (p_s, xy_s, z);
    or  u_o0 (f_c, g_s, p_s);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_sr_q, s_sr_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fa_s_s;
    logic             fa_c_s;

    fulladder_structural u_fa (
        .x   (a_sr_q[0]),
        .y   (b_sr_q[0]),
        .z   (c_q),
        .f_s (fa_s_s),
        .f_c (fa_c_s)
    );

    // Next-state, datapath shift and registered-output decode
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                s_sr_d = {fa_s_s, s_sr_q[WIDTH-1:1]};
                c_d    = fa_c_s;
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                // The last bit's sum is taken straight from the cell, not from s_sr
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_s_s, s_sr_q[WIDTH-1:1]};
                    cout_d  = fa_c_s;
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8: hand-computed vectors plus a strided
// operand sweep checked against a+b+cin, with latency checked on every operation.

module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_cmp;
    int n_mis;
    int overlap_cnt;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .cin   (cin_i),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sticky record of any cycle with busy and done both high
    always @(negedge clk) begin
        if (busy && done) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation; returns after the cycle following done (back in IDLE)
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic [7:0] exp_sum, input logic exp_cout);
        int n;
        a_i   = av;
        b_i   = bv;
        cin_i = cv;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n = n + 1;
        end
        check_val({tag, "_lat"}, 32'(n), 32'd8);
        check_val({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check_val({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        tick();
        check_val({tag, "_done_clr"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int dones;
        logic [8:0] full;
        n_cmp       = 0;
        n_mis       = 0;
        overlap_cnt = 0;
        rst   = 1'b1;
        start = 1'b0;
        a_i   = 8'h00;
        b_i   = 8'h00;
        cin_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_sum", 32'(sum), 32'd0);
        check_val("rst_cout", 32'(cout), 32'd0);
        tick();

        run_op("t1", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run_op("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("t3a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        run_op("t3b", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);

        // start held high: one result every 10 cycles, immune to mid-SHIFT operand changes
        a_i   = 8'h12;
        b_i   = 8'h34;
        cin_i = 1'b0;
        start = 1'b1;
        tick();
        for (int r = 0; r < 3; r++) begin
            n = 0;
            while (!done && n < 20) begin
                if (n == 2) begin
                    a_i = 8'hFF;
                    b_i = 8'hFF;
                end
                if (n == 4) check_val("t4_hold", 32'(sum), (r == 0) ? 32'h4B : 32'h46);
                if (n == 5) begin
                    a_i = 8'h12;
                    b_i = 8'h34;
                end
                tick();
                n = n + 1;
            end
            check_val("t4_lat", 32'(n), 32'd8);
            check_val("t4_sum", 32'(sum), 32'h46);
            check_val("t4_cout", 32'(cout), 32'd0);
            if (r == 2) start = 1'b0;
            tick();
            check_val("t4_idle_busy", 32'(busy), 32'd0);
            tick();
            check_val("t4_restart", 32'(busy), (r == 2) ? 32'd0 : 32'd1);
        end

        // Reset in the 4th SHIFT cycle aborts the operation without a done pulse
        a_i   = 8'h77;
        b_i   = 8'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check_val("t5_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t5_busy", 32'(busy), 32'd0);
        check_val("t5_sum", 32'(sum), 32'd0);
        check_val("t5_cout", 32'(cout), 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones = dones + 1;
            tick();
        end
        check_val("t5_no_done", 32'(dones), 32'd0);
        run_op("t5_after", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        // Corner and strided operand sweep against a+b+cin
        begin
            logic [7:0] corners [6];
            corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    for (int c = 0; c < 2; c++) begin
                        full = 9'(corners[i]) + 9'(corners[j]) + 9'(c);
                        run_op("corner", corners[i], corners[j], c[0], full[7:0], full[8]);
                    end
                end
            end
        end
        for (int i = 0; i < 256; i += 17) begin
            for (int j = 0; j < 256; j += 15) begin
                for (int c = 0; c < 2; c++) begin
                    full = 9'(i) + 9'(j) + 9'(c);
                    run_op("sweep", 8'(i), 8'(j), c[0], full[7:0], full[8]);
                end
            end
        end

        check_val("busy_done_excl", 32'(overlap_cnt), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
